// File: rtl/bin2bcd_hex_display.sv
// Sequential binary-to-decimal converter (double-dabble) driving active-low
// seven-segment digits with sign, leading-zero blanking and overflow display.
module bin2bcd_hex_display #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      VALUE,
    input  logic                  SIGNED_MODE,
    input  logic                  BLANK,
    input  logic                  LOAD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [8*DIGITS-1:0]   HEX
);

    // ceil(WIDTH/3) decimal digits always hold 2^WIDTH-1; never fewer than DIGITS
    localparam int unsigned BCD_N = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
    localparam int unsigned BCD_W = 4 * BCD_N;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {IDLE, PREP, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               sgn_q, sgn_d;
    logic               blank_q, blank_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_d, done_d, ovf_d;
    logic [8*DIGITS-1:0] hex_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W:0]     bcd_sh;
    logic               ovf_c;
    logic [8*DIGITS-1:0] hex_c;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step: add-3 correction, then shift in the next magnitude bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh = {bcd_adj, mag_q[WIDTH-1]};
    end

    // Display image of the post-shift BCD value, used on the final shift
    always_comb begin
        int  avail;
        logic seen;
        logic [3:0] digit;
        avail = sgn_q ? int'(DIGITS) - 1 : int'(DIGITS);
        ovf_c = bcd_sh[BCD_W];
        seen  = 1'b0;
        digit = 4'd0;
        hex_c = '1;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (i >= avail && bcd_sh[4*i +: 4] != 4'd0) begin
                ovf_c = 1'b1;
            end
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            digit = bcd_sh[4*i +: 4];
            if (ovf_c) begin
                hex_c[8*i +: 8] = SEG_MINUS;
            end else if (i >= avail) begin
                hex_c[8*i +: 8] = neg_q ? SEG_MINUS : SEG_BLANK;
            end else begin
                if (digit != 4'd0) begin
                    seen = 1'b1;
                end
                if (blank_q && !seen && i != 0) begin
                    hex_c[8*i +: 8] = SEG_BLANK;
                end else begin
                    hex_c[8*i +: 8] = seg7(digit);
                end
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        sgn_d   = sgn_q;
        blank_d = blank_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = BUSY;
        done_d  = 1'b0;
        ovf_d   = OVF;
        hex_d   = HEX;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    value_d = VALUE;
                    sgn_d   = SIGNED_MODE;
                    blank_d = BLANK;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits an unsigned WIDTH-bit magnitude
                neg_d   = sgn_q & value_q[WIDTH-1];
                mag_d   = neg_d ? (~value_q + WIDTH'(1)) : value_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = bcd_sh[BCD_W-1:0];
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hex_d   = hex_c;
                    ovf_d   = ovf_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            value_q <= '0;
            sgn_q   <= 1'b0;
            blank_q <= 1'b0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            OVF     <= 1'b0;
            HEX     <= '1;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            sgn_q   <= sgn_d;
            blank_q <= blank_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            OVF     <= ovf_d;
            HEX     <= hex_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_hex_display.sv
// Bench for bin2bcd_hex_display: a 6-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_hex_display;

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S4 = 8'h99;
    localparam logic [7:0] S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8, S8 = 8'h80, S9 = 8'h90;
    localparam logic [7:0] SM = 8'hBF, SB = 8'hFF;

    typedef struct {
        logic [7:0]  value;
        logic        sgn;
        logic        blank;
        logic [47:0] hex6;
        logic        ovf6;
        logic [15:0] hex2;
        logic        ovf2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  value = '0;
    logic        sgn = 1'b0;
    logic        blank = 1'b0;
    logic        load = 1'b0;
    logic        busy6, done6, ovf6, busy2, done2, ovf2;
    logic [47:0] hex6;
    logic [15:0] hex2;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[13];
    vec_t e;

    always #5 clk = ~clk;

    bin2bcd_hex_display #(.WIDTH(8), .DIGITS(6)) u6 (
        .CLK(clk), .RESET_N(rst_n), .VALUE(value), .SIGNED_MODE(sgn), .BLANK(blank),
        .LOAD(load), .BUSY(busy6), .DONE(done6), .OVF(ovf6), .HEX(hex6)
    );

    bin2bcd_hex_display #(.WIDTH(8), .DIGITS(2)) u2 (
        .CLK(clk), .RESET_N(rst_n), .VALUE(value), .SIGNED_MODE(sgn), .BLANK(blank),
        .LOAD(load), .BUSY(busy2), .DONE(done2), .OVF(ovf2), .HEX(hex2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every DONE must match the oldest outstanding accepted load
    always @(negedge clk) begin
        if (done6 || done2) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0b%0b required=00", done6, done2);
            end else begin
                e = sb.pop_front();
                chk($sformatf("hex6[%0h]", e.value), 64'(hex6), 64'(e.hex6));
                chk($sformatf("ovf6[%0h]", e.value), 64'(ovf6), 64'(e.ovf6));
                chk($sformatf("hex2[%0h]", e.value), 64'(hex2), 64'(e.hex2));
                chk($sformatf("ovf2[%0h]", e.value), 64'(ovf2), 64'(e.ovf2));
                chk("done_both", 64'({done6, done2}), 64'(2'b11));
            end
        end
    end

    task automatic start(input vec_t v);
        @(negedge clk);
        value = v.value;
        sgn   = v.sgn;
        blank = v.blank;
        load  = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 40; t++) begin
            if (!busy6) break;
            @(negedge clk);
        end
        if (busy6) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
    endtask

    initial begin
        tbl[0]  = '{8'hF0, 1'b0, 1'b0, {S0,S0,S0,S2,S4,S0}, 1'b0, {SM,SM}, 1'b1};
        tbl[1]  = '{8'hF0, 1'b1, 1'b1, {SM,SB,SB,SB,S1,S6}, 1'b0, {SM,SM}, 1'b1};
        tbl[2]  = '{8'h80, 1'b1, 1'b1, {SM,SB,SB,S1,S2,S8}, 1'b0, {SM,SM}, 1'b1};
        tbl[3]  = '{8'd100, 1'b0, 1'b0, {S0,S0,S0,S1,S0,S0}, 1'b0, {SM,SM}, 1'b1};
        tbl[4]  = '{8'd99, 1'b0, 1'b0, {S0,S0,S0,S0,S9,S9}, 1'b0, {S9,S9}, 1'b0};
        tbl[5]  = '{8'hF7, 1'b1, 1'b0, {SM,S0,S0,S0,S0,S9}, 1'b0, {SM,S9}, 1'b0};
        tbl[6]  = '{8'h00, 1'b1, 1'b1, {SB,SB,SB,SB,SB,S0}, 1'b0, {SB,S0}, 1'b0};
        tbl[7]  = '{8'hFF, 1'b0, 1'b1, {SB,SB,SB,S2,S5,S5}, 1'b0, {SM,SM}, 1'b1};
        tbl[8]  = '{8'h7F, 1'b1, 1'b0, {SB,S0,S0,S1,S2,S7}, 1'b0, {SM,SM}, 1'b1};
        tbl[9]  = '{8'h05, 1'b1, 1'b1, {SB,SB,SB,SB,SB,S5}, 1'b0, {SB,S5}, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b0, {S0,S0,S0,S0,S0,S0}, 1'b0, {S0,S0}, 1'b0};
        tbl[11] = '{8'd10, 1'b0, 1'b1, {SB,SB,SB,SB,S1,S0}, 1'b0, {S1,S0}, 1'b0};
        tbl[12] = '{8'h09, 1'b1, 1'b0, {SB,S0,S0,S0,S0,S9}, 1'b0, {SB,S9}, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hex6", 64'(hex6), 64'({6{SB}}));
        chk("rst_hex2", 64'(hex2), 64'({2{SB}}));
        chk("rst_flags", 64'({busy6, done6, ovf6, busy2, done2, ovf2}), 64'(0));

        // Latency of the first conversion: BUSY over edges k..k+8, DONE at k+9
        start(tbl[0]);
        chk("busy_k", 64'({busy6, done6}), 64'(2'b10));
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("busy_k%0d", j), 64'({busy6, done6}), 64'(2'b10));
            if (j == 4) chk("hold_hex6", 64'(hex6), 64'({6{SB}}));
        end
        @(negedge clk);
        chk("done_k9", 64'({busy6, done6}), 64'(2'b01));
        @(negedge clk);
        chk("done_k10", 64'(done6), 64'(0));

        for (int i = 1; i < 13; i++) begin
            start(tbl[i]);
            wait_done();
        end

        // LOAD held three cycles, then a fresh LOAD at k+4: one conversion of the first value
        @(negedge clk);
        value = tbl[0].value;
        sgn   = tbl[0].sgn;
        blank = tbl[0].blank;
        load  = 1'b1;
        sb.push_back(tbl[0]);
        repeat (3) @(negedge clk);
        load  = 1'b0;
        @(negedge clk);
        value = 8'd99;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        chk("ignored_hex6", 64'(hex6), 64'(tbl[0].hex6));

        // Reset before edge k+5 aborts with no update and no DONE
        value = 8'd99;
        sgn   = 1'b0;
        blank = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hex6", 64'(hex6), 64'({6{SB}}));
        chk("abort_hex2", 64'(hex2), 64'({2{SB}}));
        chk("abort_flags", 64'({busy6, ovf2}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_after_hex6", 64'(hex6), 64'({6{SB}}));
        chk("abort_after_busy", 64'(busy6), 64'(0));

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
